// File: rtl/receptor_movimentos.sv
// rtl/receptor_movimentos.sv - receives a text movement list over serial bytes and stores it encoded in RAM
// Optional echo of accepted bytes on tx_dado/tx_partida when RECEPTOR_ECO_EN is defined.
module receptor_movimentos #(
   parameter int MAX_MOV = 48
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       obter_movimentos,
   input  logic [7:0] rx_dado,
   input  logic       rx_pronto,
   output logic       movimentos_recebidos,
   output logic       erro_movimento,
   output logic       mem_escreve,
   output logic [5:0] mem_endereco,
   output logic [4:0] mem_dado,
   output logic [5:0] num_movimentos,
   output logic [2:0] db_estado
`ifdef RECEPTOR_ECO_EN
   ,
   output logic [7:0] tx_dado,
   output logic       tx_partida
`endif
);

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      ESPERA_FACE = 3'd1,
      ESPERA_MOD  = 3'd2,
      CONCLUIDO   = 3'd3,
      ERRO        = 3'd4
   } estado_t;

   estado_t    r_estado, w_prox;
   logic [2:0] r_face;
   logic       r_escreve;
   logic [5:0] r_endereco, r_num;
   logic [4:0] r_dado;

   logic       w_eh_face, w_eh_mod, w_eh_sep, w_eh_lf;
   logic [2:0] w_face_cod;
   logic [1:0] w_mod_cod, w_turn;
   logic       w_grava, w_grava_ok, w_nova_face, w_aceita, w_cheio;
   logic [5:0] w_cnt;

   always_comb begin
      w_eh_face  = 1'b1;
      w_face_cod = 3'd0;
      case (rx_dado)
         8'h55:   w_face_cod = 3'd0;
         8'h44:   w_face_cod = 3'd1;
         8'h46:   w_face_cod = 3'd2;
         8'h42:   w_face_cod = 3'd3;
         8'h4C:   w_face_cod = 3'd4;
         8'h52:   w_face_cod = 3'd5;
         default: w_eh_face  = 1'b0;
      endcase
   end

   assign w_eh_mod  = (rx_dado == 8'h27) || (rx_dado == 8'h32);
   assign w_mod_cod = (rx_dado == 8'h27) ? 2'b01 : 2'b10;
   assign w_eh_sep  = (rx_dado == 8'h20) || (rx_dado == 8'h0D);
   assign w_eh_lf   = (rx_dado == 8'h0A);

   // A write issued last cycle has not yet been folded into r_num.
   assign w_cnt      = r_num + {5'd0, r_escreve};
   assign w_cheio    = (w_cnt == 6'(MAX_MOV));
   assign w_grava_ok = w_grava && !w_cheio;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_estado <= OCIOSO;
      else        r_estado <= w_prox;
   end

   always_comb begin
      w_prox      = r_estado;
      w_grava     = 1'b0;
      w_turn      = 2'b00;
      w_nova_face = 1'b0;
      w_aceita    = 1'b0;
      case (r_estado)
         OCIOSO: if (obter_movimentos) w_prox = ESPERA_FACE;
         ESPERA_FACE: begin
            if (!obter_movimentos) w_prox = OCIOSO;
            else if (rx_pronto) begin
               w_aceita = 1'b1;
               if (w_eh_sep)       w_prox = ESPERA_FACE;
               else if (w_eh_face) begin
                  w_nova_face = 1'b1;
                  w_prox      = ESPERA_MOD;
               end
               else if (w_eh_lf)   w_prox = CONCLUIDO;
               else                w_prox = ERRO;
            end
         end
         ESPERA_MOD: begin
            if (!obter_movimentos) w_prox = OCIOSO;
            else if (rx_pronto) begin
               w_aceita = 1'b1;
               w_grava  = 1'b1;
               if (w_eh_mod) begin
                  w_turn = w_mod_cod;
                  w_prox = ESPERA_FACE;
               end
               else if (w_eh_sep)  w_prox = ESPERA_FACE;
               else if (w_eh_lf)   w_prox = CONCLUIDO;
               else if (w_eh_face) begin
                  w_nova_face = 1'b1;
                  w_prox      = ESPERA_MOD;
               end
               else begin
                  w_grava = 1'b0;
                  w_prox  = ERRO;
               end
               if (w_grava && w_cheio) w_prox = ERRO;
            end
         end
         CONCLUIDO, ERRO: if (!obter_movimentos) w_prox = OCIOSO;
         default: w_prox = OCIOSO;
      endcase
   end

   always_comb begin
      movimentos_recebidos = 1'b0;
      erro_movimento       = 1'b0;
      db_estado            = r_estado;
      if (r_estado == CONCLUIDO) movimentos_recebidos = 1'b1;
      if (r_estado == ERRO)      erro_movimento       = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_escreve  <= 1'b0;
         r_endereco <= 6'd0;
         r_num      <= 6'd0;
         r_dado     <= 5'd0;
         r_face     <= 3'd0;
      end else begin
         r_escreve <= w_grava_ok;
         if (r_estado == OCIOSO && obter_movimentos) begin
            r_num      <= 6'd0;
            r_endereco <= 6'd0;
         end else if (w_grava_ok) begin
            r_endereco <= w_cnt;
            r_num      <= w_cnt;
            r_dado     <= {r_face, w_turn};
         end else if (r_escreve) begin
            r_num      <= r_num + 6'd1;
            r_endereco <= r_endereco + 6'd1;
         end
         if (w_nova_face) r_face <= w_face_cod;
      end
   end

   assign mem_escreve    = r_escreve;
   assign mem_endereco   = r_endereco;
   assign mem_dado       = r_dado;
   assign num_movimentos = r_num;

`ifdef RECEPTOR_ECO_EN
   logic [7:0] r_tx_dado;
   logic       r_tx_partida;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tx_dado    <= 8'd0;
         r_tx_partida <= 1'b0;
      end else begin
         r_tx_partida <= w_aceita;
         if (w_aceita) r_tx_dado <= rx_dado;
      end
   end

   assign tx_dado    = r_tx_dado;
   assign tx_partida = r_tx_partida;
`endif

endmodule

// File: tb/tb_receptor_movimentos.sv
// tb/tb_receptor_movimentos.sv - scoreboard bench for receptor_movimentos (default and MAX_MOV=2 instances)
module tb_receptor_movimentos;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       obter = 1'b0;
   logic       obter2 = 1'b0;
   logic [7:0] rx_dado = 8'd0;
   logic       rx_pronto = 1'b0;

   logic       rec, erro, wr;
   logic [5:0] addr, num;
   logic [4:0] dado;
   logic [2:0] est;
   logic       rec2, erro2, wr2;
   logic [5:0] addr2, num2;
   logic [4:0] dado2;
   logic [2:0] est2;
`ifdef RECEPTOR_ECO_EN
   logic [7:0] tx_dado, tx_dado2;
   logic       tx_partida, tx_partida2;
   bit         eco_chk = 1'b0;
   logic [7:0] qe[$];
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [10:0] q1[$];
   logic [10:0] q2[$];

   always #5 clock = ~clock;

   receptor_movimentos dut (
      .clock(clock), .reset(reset), .obter_movimentos(obter),
      .rx_dado(rx_dado), .rx_pronto(rx_pronto),
      .movimentos_recebidos(rec), .erro_movimento(erro),
      .mem_escreve(wr), .mem_endereco(addr), .mem_dado(dado),
      .num_movimentos(num), .db_estado(est)
`ifdef RECEPTOR_ECO_EN
      , .tx_dado(tx_dado), .tx_partida(tx_partida)
`endif
   );

   receptor_movimentos #(.MAX_MOV(2)) dut2 (
      .clock(clock), .reset(reset), .obter_movimentos(obter2),
      .rx_dado(rx_dado), .rx_pronto(rx_pronto),
      .movimentos_recebidos(rec2), .erro_movimento(erro2),
      .mem_escreve(wr2), .mem_endereco(addr2), .mem_dado(dado2),
      .num_movimentos(num2), .db_estado(est2)
`ifdef RECEPTOR_ECO_EN
      , .tx_dado(tx_dado2), .tx_partida(tx_partida2)
`endif
   );

   task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
      end
   endtask

   // Monitors: every write must match the next expected {address, data}.
   always @(negedge clock) begin
      if (wr === 1'b1) begin
         if (q1.size() == 0) check("unexpected_write", {26'd0, addr, dado}, 32'h7FF);
         else begin
            logic [10:0] e;
            e = q1.pop_front();
            check("write_addr", {26'd0, addr}, {26'd0, e[10:5]});
            check("write_data", {27'd0, dado}, {27'd0, e[4:0]});
            check("write_num",  {26'd0, num},  {26'd0, e[10:5]});
         end
      end
      if (wr2 === 1'b1) begin
         if (q2.size() == 0) check("unexpected_write2", {26'd0, addr2, dado2}, 32'h7FF);
         else begin
            logic [10:0] e;
            e = q2.pop_front();
            check("write2_addr", {26'd0, addr2}, {26'd0, e[10:5]});
            check("write2_data", {27'd0, dado2}, {27'd0, e[4:0]});
         end
      end
`ifdef RECEPTOR_ECO_EN
      if (eco_chk && tx_partida === 1'b1) begin
         if (qe.size() == 0) check("unexpected_echo", {24'd0, tx_dado}, 32'h1FF);
         else check("echo_byte", {24'd0, tx_dado}, {24'd0, qe.pop_front()});
      end
`endif
   end

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      rx_dado   = b;
      rx_pronto = 1'b1;
      @(negedge clock);
      rx_pronto = 1'b0;
      rx_dado   = 8'd0;
      repeat (2) @(negedge clock);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      wait_cyc(3);
      check("rst_estado", {29'd0, est}, 32'd0);
      check("rst_rec",    {31'd0, rec}, 32'd0);
      check("rst_erro",   {31'd0, erro}, 32'd0);
      check("rst_wr",     {31'd0, wr}, 32'd0);
      check("rst_addr",   {26'd0, addr}, 32'd0);
      check("rst_dado",   {27'd0, dado}, 32'd0);
      check("rst_num",    {26'd0, num}, 32'd0);
      reset = 1'b1;
      wait_cyc(2);

      // "R U' F2\n"
      obter = 1'b1;
      wait_cyc(2);
      check("start_estado", {29'd0, est}, 32'd1);
      q1.push_back({6'd0, 5'h14});
      q1.push_back({6'd1, 5'h01});
      q1.push_back({6'd2, 5'h0A});
      send("R"); send(" "); send("U"); send(8'h27); send(" ");
      send("F"); send("2"); send(8'h0A);
      check("l1_num", {26'd0, num}, 32'd3);
      check("l1_rec", {31'd0, rec}, 32'd1);
      check("l1_estado", {29'd0, est}, 32'd3);
      obter = 1'b0;
      wait_cyc(2);
      check("l1_idle", {29'd0, est}, 32'd0);
      check("l1_num_hold", {26'd0, num}, 32'd3);
      check("l1_rec_low", {31'd0, rec}, 32'd0);

      // "RU\n"
      obter = 1'b1;
      wait_cyc(2);
      check("l2_num_clear", {26'd0, num}, 32'd0);
      q1.push_back({6'd0, 5'h14});
      q1.push_back({6'd1, 5'h00});
      send("R"); send("U"); send(8'h0A);
      check("l2_num", {26'd0, num}, 32'd2);
      check("l2_rec", {31'd0, rec}, 32'd1);
      obter = 1'b0;
      wait_cyc(2);

      // "\n" alone
      obter = 1'b1;
      wait_cyc(2);
      send(8'h0A);
      check("l3_estado", {29'd0, est}, 32'd3);
      check("l3_num", {26'd0, num}, 32'd0);
      obter = 1'b0;
      wait_cyc(2);

      // "R X" then ignored byte in ERRO
      obter = 1'b1;
      wait_cyc(2);
      q1.push_back({6'd0, 5'h14});
      send("R"); send(" "); send("X");
      check("l4_erro", {31'd0, erro}, 32'd1);
      check("l4_estado", {29'd0, est}, 32'd4);
      check("l4_num", {26'd0, num}, 32'd1);
      send("U");
      check("l4_hold", {29'd0, est}, 32'd4);
      obter = 1'b0;
      wait_cyc(2);
      check("l4_idle", {29'd0, est}, 32'd0);
      check("l4_erro_low", {31'd0, erro}, 32'd0);

      // modifier where a face is expected
      obter = 1'b1;
      wait_cyc(2);
      send(8'h27);
      check("mod_first", {29'd0, est}, 32'd4);
      obter = 1'b0;
      wait_cyc(2);

      // abort in the same cycle as rx_pronto
      obter = 1'b1;
      wait_cyc(2);
      @(negedge clock);
      rx_dado = "R"; rx_pronto = 1'b1; obter = 1'b0;
      @(negedge clock);
      rx_pronto = 1'b0; rx_dado = 8'd0;
      wait_cyc(2);
      check("abort_estado", {29'd0, est}, 32'd0);
      check("abort_num", {26'd0, num}, 32'd0);

      // pending face discarded on abort
      obter = 1'b1;
      wait_cyc(2);
      send("R");
      obter = 1'b0;
      wait_cyc(2);
      check("pend_idle", {29'd0, est}, 32'd0);
      obter = 1'b1;
      wait_cyc(2);
      q1.push_back({6'd0, 5'h00});
      send("U"); send(8'h0A);
      check("pend_num", {26'd0, num}, 32'd1);
      obter = 1'b0;
      wait_cyc(2);

      // capacity limit on the MAX_MOV=2 instance
      obter2 = 1'b1;
      wait_cyc(2);
      q2.push_back({6'd0, 5'h14});
      q2.push_back({6'd1, 5'h00});
      send("R"); send(" "); send("U"); send(" "); send("F"); send(8'h0A);
      check("full_erro", {31'd0, erro2}, 32'd1);
      check("full_estado", {29'd0, est2}, 32'd4);
      check("full_num", {26'd0, num2}, 32'd2);
      check("full_other_idle", {29'd0, est}, 32'd0);
      obter2 = 1'b0;
      wait_cyc(2);
      check("full_idle", {29'd0, est2}, 32'd0);

`ifdef RECEPTOR_ECO_EN
      eco_chk = 1'b1;
      obter = 1'b1;
      wait_cyc(2);
      qe.push_back(8'h55);
      qe.push_back(8'h0A);
      q1.push_back({6'd0, 5'h00});
      send("U"); send(8'h0A);
      check("eco_rec", {31'd0, rec}, 32'd1);
      check("eco_q_empty", qe.size(), 32'd0);
      obter = 1'b0;
      wait_cyc(2);
      eco_chk = 1'b0;
`endif

      // reset in the middle of a reception
      obter = 1'b1;
      wait_cyc(2);
      send("R");
      @(negedge clock);
      reset = 1'b0;
      obter = 1'b0;
      wait_cyc(2);
      check("mid_rst_estado", {29'd0, est}, 32'd0);
      check("mid_rst_num", {26'd0, num}, 32'd0);
      reset = 1'b1;
      wait_cyc(4);

      check("q1_drained", q1.size(), 32'd0);
      check("q2_drained", q2.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
